// File: rtl/tftp_rx_pkg.sv
// Shared constants for the Ethernet/TFTP receive path: FSM states, header offsets,
// protocol constants and a bit-reversal helper for the reflected CRC.
package tftp_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_FRAME,
    ST_DROP
  } rx_state_t;

  localparam int unsigned ETH_TYPE_OFF = 12;
  localparam int unsigned IP_VIHL_OFF  = 14;
  localparam int unsigned IP_PROTO_OFF = 23;
  localparam int unsigned UDP_DST_OFF  = 36;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VIHL_5      = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  SFD            = 8'hD5;
  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [31:0] CRC_POLY       = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB of data first).
module eth_crc32_byte
  import tftp_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = bitrev32(CRC_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_frame.sv
// Ethernet receive front end: strips preamble/SFD, indexes frame bytes, extracts the UDP
// destination port and IPv4/UDP flag. FCS checking is built only when RX_FCS_CHECK_EN is defined.
module eth_rx_frame
  import tftp_rx_pkg::*;
#(
  parameter int unsigned PREAMBLE_MIN = 2,
  parameter int unsigned LEN_W        = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_dv,
  input  logic [7:0]       rx_data,
  output logic             byte_valid,
  output logic [7:0]       cnt,
  output logic [7:0]       eth_data,
  output logic [15:0]      udp_dst,
  output logic             is_ipv4_udp,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic             fcs_ok
);

  localparam logic [7:0]       PRE_MIN_B  = 8'(PREAMBLE_MIN);
  localparam logic [LEN_W-1:0] OFF_TYPE0  = LEN_W'(ETH_TYPE_OFF);
  localparam logic [LEN_W-1:0] OFF_TYPE1  = LEN_W'(ETH_TYPE_OFF + 1);
  localparam logic [LEN_W-1:0] OFF_VIHL   = LEN_W'(IP_VIHL_OFF);
  localparam logic [LEN_W-1:0] OFF_PROTO  = LEN_W'(IP_PROTO_OFF);
  localparam logic [LEN_W-1:0] OFF_UDP_HI = LEN_W'(UDP_DST_OFF);
  localparam logic [LEN_W-1:0] OFF_UDP_LO = LEN_W'(UDP_DST_OFF + 1);
  localparam logic [7:0]       TYPE_HI    = ETHERTYPE_IPV4[15:8];
  localparam logic [7:0]       TYPE_LO    = ETHERTYPE_IPV4[7:0];

  rx_state_t        state;
  logic [7:0]       pre_cnt;
  logic [LEN_W-1:0] len_cnt;
  logic [7:0]       udp_hi;
  logic             hdr_ok;

`ifdef RX_FCS_CHECK_EN
  localparam logic [31:0] RESIDUE_REFL = bitrev32(CRC_RESIDUE);

  logic [31:0] crc_q;
  logic [31:0] crc_next;

  eth_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data    (rx_data),
    .crc_out (crc_next)
  );
`else
  assign fcs_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pre_cnt     <= '0;
      len_cnt     <= '0;
      udp_hi      <= '0;
      hdr_ok      <= 1'b0;
      byte_valid  <= 1'b0;
      cnt         <= '0;
      eth_data    <= '0;
      udp_dst     <= '0;
      is_ipv4_udp <= 1'b0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
`ifdef RX_FCS_CHECK_EN
      crc_q       <= '1;
      fcs_ok      <= 1'b0;
`endif
    end else begin
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_dv) begin
            if (rx_data == PREAMBLE_BYTE) begin
              state   <= ST_PREAMBLE;
              pre_cnt <= 8'd1;
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
          end else if (rx_data == PREAMBLE_BYTE) begin
            if (pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
          end else if (rx_data == SFD && pre_cnt >= PRE_MIN_B) begin
            state       <= ST_FRAME;
            len_cnt     <= '0;
            udp_dst     <= '0;
            is_ipv4_udp <= 1'b0;
            hdr_ok      <= 1'b0;
`ifdef RX_FCS_CHECK_EN
            crc_q       <= '1;
`endif
          end else begin
            state <= ST_DROP;
          end
        end
        ST_FRAME: begin
          if (!rx_dv) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
            frame_len  <= len_cnt;
`ifdef RX_FCS_CHECK_EN
            fcs_ok     <= (crc_q == RESIDUE_REFL);
`endif
          end else begin
            eth_data   <= rx_data;
            byte_valid <= 1'b1;
            // len_cnt doubles as the index of the incoming byte; it never returns to 0 mid-frame.
            if (len_cnt == '0)       cnt <= '0;
            else if (cnt != 8'hFF)   cnt <= cnt + 8'd1;
            if (len_cnt != '1)       len_cnt <= len_cnt + 1'b1;
            if (len_cnt == OFF_TYPE0) hdr_ok <= (rx_data == TYPE_HI);
            if (len_cnt == OFF_TYPE1) hdr_ok <= hdr_ok && (rx_data == TYPE_LO);
            if (len_cnt == OFF_VIHL)  hdr_ok <= hdr_ok && (rx_data == IP_VIHL_5);
            if (len_cnt == OFF_PROTO) is_ipv4_udp <= hdr_ok && (rx_data == IP_PROTO_UDP);
            if (len_cnt == OFF_UDP_HI) udp_hi <= rx_data;
            if (len_cnt == OFF_UDP_LO) udp_dst <= {udp_hi, rx_data};
`ifdef RX_FCS_CHECK_EN
            crc_q <= crc_next;
`endif
          end
        end
        ST_DROP: begin
          if (!rx_dv) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame.sv
// Randomized self-checking bench for eth_rx_frame against a frame-level reference model.
module tb_eth_rx_frame;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic        byte_valid;
  logic [7:0]  cnt;
  logic [7:0]  eth_data;
  logic [15:0] udp_dst;
  logic        is_ipv4_udp;
  logic        frame_done;
  logic [10:0] frame_len;
  logic        fcs_ok;

  eth_rx_frame #(.PREAMBLE_MIN(2), .LEN_W(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_dv       (rx_dv),
    .rx_data     (rx_data),
    .byte_valid  (byte_valid),
    .cnt         (cnt),
    .eth_data    (eth_data),
    .udp_dst     (udp_dst),
    .is_ipv4_udp (is_ipv4_udp),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .fcs_ok      (fcs_ok)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  frm[$];
  logic [7:0]  stream[$];
  int unsigned last_len;
  logic        last_fcs;

`ifdef RX_FCS_CHECK_EN
  localparam logic FCS_AFTER_RESET = 1'b0;
  localparam logic FCS_MODELLED    = 1'b1;
`else
  localparam logic FCS_AFTER_RESET = 1'b1;
  localparam logic FCS_MODELLED    = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] frame_fcs(input int unsigned n);
    logic [31:0] c;
    c = '1;
    for (int unsigned i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic set_byte(input int idx, input logic [7:0] v);
    if (idx < frm.size()) frm[idx] = v;
  endtask

  // kind: 0 random, 1 IPv4/UDP with given port, 2 ARP; len includes the 4 FCS bytes
  task automatic make_frame(input int unsigned len, input int unsigned kind, input logic [15:0] port);
    logic [31:0] fcs;
    frm.delete();
    for (int unsigned i = 0; i < len - 4; i++) frm.push_back(8'($urandom));
    if (kind == 1) begin
      set_byte(12, 8'h08); set_byte(13, 8'h00); set_byte(14, 8'h45); set_byte(23, 8'h11);
      set_byte(36, port[15:8]); set_byte(37, port[7:0]);
    end else if (kind == 2) begin
      set_byte(12, 8'h08); set_byte(13, 8'h06);
    end
    fcs = frame_fcs(len - 4);
    frm.push_back(fcs[7:0]);   frm.push_back(fcs[15:8]);
    frm.push_back(fcs[23:16]); frm.push_back(fcs[31:24]);
  endtask

  task automatic check_after(input int k, input int fstart, input int rst_at);
    int i;
    logic [15:0] exp_udp;
    logic        exp_ip;
    if (rst_at >= 0 && k == rst_at) begin
      check_val("rst_byte_valid", 32'(byte_valid), 32'd0);
      check_val("rst_cnt", 32'(cnt), 32'd0);
      check_val("rst_eth_data", 32'(eth_data), 32'd0);
      check_val("rst_udp_dst", 32'(udp_dst), 32'd0);
      check_val("rst_is_ipv4_udp", 32'(is_ipv4_udp), 32'd0);
      check_val("rst_frame_done", 32'(frame_done), 32'd0);
      check_val("rst_frame_len", 32'(frame_len), 32'd0);
      check_val("rst_fcs_ok", 32'(fcs_ok), 32'(FCS_AFTER_RESET));
    end else if (fstart >= 0 && k >= fstart && !(rst_at >= 0 && k > rst_at)) begin
      i = k - fstart;
      exp_udp = 16'd0;
      if (i >= 37) exp_udp = {frm[36], frm[37]};
      exp_ip = 1'b0;
      if (i >= 23) exp_ip = (frm[12] == 8'h08) && (frm[13] == 8'h00) &&
                            (frm[14] == 8'h45) && (frm[23] == 8'h11);
      check_val("byte_valid", 32'(byte_valid), 32'd1);
      check_val("cnt", 32'(cnt), (i > 255) ? 32'd255 : 32'(i));
      check_val("eth_data", 32'(eth_data), 32'(frm[i]));
      check_val("udp_dst", 32'(udp_dst), 32'(exp_udp));
      check_val("is_ipv4_udp", 32'(is_ipv4_udp), 32'(exp_ip));
      check_val("frame_done_mid", 32'(frame_done), 32'd0);
    end else begin
      check_val("idle_byte_valid", 32'(byte_valid), 32'd0);
      check_val("idle_frame_done", 32'(frame_done), 32'd0);
    end
  endtask

  task automatic drive_stream(input int fstart, input int rst_at, input logic fcs_good);
    int          n;
    logic        exp_done;
    int unsigned nf;
    n = stream.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k > 0) check_after(k - 1, fstart, rst_at);
      rx_dv   = 1'b1;
      rx_data = stream[k];
      reset   = (k == rst_at);
    end
    @(negedge clk);
    check_after(n - 1, fstart, rst_at);
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    reset   = 1'b0;
    if (rst_at >= 0) begin
      last_len = 0;
      last_fcs = FCS_AFTER_RESET;
    end
    @(negedge clk);
    exp_done = (fstart >= 0 && rst_at < 0);
    check_val("frame_done", 32'(frame_done), 32'(exp_done));
    check_val("end_byte_valid", 32'(byte_valid), 32'd0);
    if (exp_done) begin
      nf = int'(n - fstart);
      last_len = (nf > 2047) ? 2047 : nf;
      last_fcs = FCS_MODELLED ? fcs_good : 1'b1;
      check_val("cnt_hold", 32'(cnt), (nf - 1 > 255) ? 32'd255 : 32'(nf - 1));
    end
    check_val("frame_len", 32'(frame_len), 32'(last_len));
    check_val("fcs_ok", 32'(fcs_ok), 32'(last_fcs));
    @(negedge clk);
    check_val("frame_done_pulse", 32'(frame_done), 32'd0);
    check_val("fcs_ok_hold", 32'(fcs_ok), 32'(last_fcs));
    @(negedge clk);
  endtask

  task automatic send_frame(input int npre, input logic accept, input int rst_idx, input logic fcs_good);
    stream.delete();
    repeat (npre) stream.push_back(8'h55);
    stream.push_back(8'hD5);
    foreach (frm[i]) stream.push_back(frm[i]);
    drive_stream(accept ? npre + 1 : -1, (accept && rst_idx >= 0) ? npre + 1 + rst_idx : -1, fcs_good);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    rx_dv    = 1'b0;
    rx_data  = 8'h00;
    last_len = 0;
    last_fcs = FCS_AFTER_RESET;
    repeat (3) @(negedge clk);
    check_val("reset_byte_valid", 32'(byte_valid), 32'd0);
    check_val("reset_cnt", 32'(cnt), 32'd0);
    check_val("reset_eth_data", 32'(eth_data), 32'd0);
    check_val("reset_udp_dst", 32'(udp_dst), 32'd0);
    check_val("reset_is_ipv4_udp", 32'(is_ipv4_udp), 32'd0);
    check_val("reset_frame_done", 32'(frame_done), 32'd0);
    check_val("reset_frame_len", 32'(frame_len), 32'd0);
    check_val("reset_fcs_ok", 32'(fcs_ok), 32'(FCS_AFTER_RESET));
    reset = 1'b0;
    @(negedge clk);

    make_frame(71, 1, 16'h0045);
    send_frame(7, 1'b1, -1, 1'b1);
    make_frame(60, 2, 16'(($urandom)));
    send_frame(7, 1'b1, -1, 1'b1);

    stream.delete();
    stream.push_back(8'h12);
    repeat (19) stream.push_back(8'($urandom));
    drive_stream(-1, -1, 1'b1);
    make_frame(64, 1, 16'(($urandom)));
    send_frame(3, 1'b1, -1, 1'b1);

    make_frame(50, 1, 16'h1234);
    send_frame(1, 1'b0, -1, 1'b1);
    send_frame(2, 1'b1, -1, 1'b1);

    make_frame(300, 1, 16'h0045);
    send_frame(7, 1'b1, -1, 1'b1);
    frm[100] = frm[100] ^ 8'h10;
    send_frame(7, 1'b1, -1, 1'b0);
    make_frame(2100, 0, 16'h0000);
    send_frame(7, 1'b1, -1, 1'b1);
    make_frame(20, 1, 16'h0045);
    send_frame(5, 1'b1, -1, 1'b1);

    make_frame(80, 1, 16'h0045);
    if (frm[21] == 8'h55) frm[21] = 8'h00;
    send_frame(7, 1'b1, 20, 1'b1);
    make_frame(71, 1, 16'h0045);
    send_frame(7, 1'b1, -1, 1'b1);

    repeat (10) begin
      make_frame($urandom_range(150, 24), $urandom_range(2, 0), 16'(($urandom)));
      send_frame(int'($urandom_range(7, 2)), 1'b1, -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame.md
Name: eth_rx_frame

Overview:
Byte-level Ethernet receive front end that sits directly upstream of tftp_decode.
- Strips preamble/SFD from the PHY byte stream.
- Produces the per-frame byte index (cnt) and registered data byte (eth_data) that tftp_decode consumes.
- Extracts the UDP destination port (udp_dst) and flags IPv4/UDP frames.
- Reports frame completion and length for the downstream TFTP logic.

Parameters:
PREAMBLE_MIN, 2, minimum count of 0x55 bytes required before SFD 0xD5 for a frame to be accepted.
LEN_W, 11, width of frame_len (saturates at 2^LEN_W-1).

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
rx_dv  input  1  PHY byte valid; contiguous high for preamble+frame, low between frames
rx_data  input  8  PHY byte
byte_valid  output  1  high when cnt/eth_data carry a frame byte
cnt  output  8  byte index within frame (0 = first dst MAC byte), saturating at 255
eth_data  output  8  frame byte registered from rx_data
udp_dst  output  16  UDP destination port (frame bytes 36,37, big-endian)
is_ipv4_udp  output  1  frame is IPv4/IHL=5/UDP
frame_done  output  1  one-cycle pulse at end of accepted frame
frame_len  output  LEN_W  byte count of the last frame, including FCS
fcs_ok  output  1  FCS result, valid with frame_done

Behaviour:
- Reset (synchronous) drives all outputs to 0, clears the internal counters and puts the FSM in IDLE.
- States: IDLE, PREAMBLE, FRAME, DROP.
  - IDLE: rx_dv & rx_data==0x55 -> PREAMBLE with pre_cnt=1. rx_dv with any other byte -> DROP.
  - PREAMBLE:
    - rx_dv low -> IDLE.
    - 0x55 -> stay, pre_cnt++ (saturating).
    - 0xD5 -> FRAME if pre_cnt>=PREAMBLE_MIN, else DROP.
    - Any other byte -> DROP.
  - FRAME:
    - Each cycle with rx_dv high: the byte is registered to eth_data, byte_valid=1 next cycle, and cnt holds the byte index (latency 1 clock rx_data -> eth_data).
    - rx_dv low -> IDLE; byte_valid=0 and frame_done pulses for that one cycle.
  - DROP: hold until rx_dv low -> IDLE. No byte_valid, no frame_done.
- cnt: 0 on first frame byte, +1 per byte, saturates at 255. cnt holds its last value when byte_valid=0.
- frame_len:
  - Internal counter is cleared on SFD and saturates at 2^LEN_W-1.
  - Copied to frame_len on frame_done and held until the next frame_done.
- udp_dst:
  - Cleared to 0 on SFD.
  - Byte 36 is stored as the high byte. On byte 37, udp_dst={hi,byte} updates in the same cycle that cnt=37 is presented.
  - Stable from then until the next SFD.
  - Runt frames (<38 bytes) leave udp_dst=0.
- is_ipv4_udp:
  - Cleared on SFD.
  - Set in the cycle cnt=23 is presented if bytes 12,13 = 0x08,0x00, byte 14 = 0x45 and byte 23 = 0x11.
  - Held until the next SFD. Frames shorter than 24 bytes give 0.
- rx_dv is assumed gap-free within a frame; any low cycle terminates the frame.
- Reset mid-frame: outputs clear the next cycle. Remaining bytes (rx_dv still high, non-0x55) send the FSM IDLE -> DROP, so no partial frame reaches tftp_decode and no frame_done is issued.

Optional Feature:
- Macro RX_FCS_CHECK_EN:
  - When defined, a CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over every FRAME byte including the 4 FCS bytes.
  - On frame_done, fcs_ok=1 iff the register equals residue 0xC704DD7B, else 0. fcs_ok holds until the next frame_done.
  - When not defined, no CRC logic is built and fcs_ok is tied 1.

Decomposition:
- Package tftp_rx_pkg holds:
  - FSM state encoding.
  - Offsets ETH_TYPE_OFF=12, IP_VIHL_OFF=14, IP_PROTO_OFF=23, UDP_DST_OFF=36.
  - ETHERTYPE_IPV4=16'h0800, IP_VIHL_5=8'h45, IP_PROTO_UDP=8'h11, SFD=8'hD5, PREAMBLE_BYTE=8'h55, CRC_RESIDUE=32'hC704DD7B.
- One sub-module, eth_crc32_byte: combinational next-CRC over 8 bits, instantiated only under RX_FCS_CHECK_EN.

Test Plan:
- 7x0x55, 0xD5, then a 71-byte TFTP request frame with UDP dst 0x0045 -> cnt 0..70 on consecutive cycles, eth_data matches input delayed 1 clk, udp_dst=0x0045 when cnt=37, is_ipv4_udp=1 when cnt=23, frame_done 1 cycle, frame_len=71.
- 60-byte ARP frame (ethertype 0x0806) -> is_ipv4_udp=0, udp_dst holds bytes 36/37 contents, frame_len=60.
- First byte 0x12 with rx_dv high for 20 cycles, then a valid frame -> no byte_valid/frame_done for the garbage; the following frame is decoded normally.
- PREAMBLE_MIN=2, sequence 0x55,0xD5,payload -> DROP, no byte_valid. Then 0x55,0x55,0xD5 -> accepted.
- 300-byte frame -> cnt saturates at 255, frame_len=300. With RX_FCS_CHECK_EN, a correct FCS gives fcs_ok=1; one payload bit flipped gives fcs_ok=0.
- reset asserted 1 cycle at byte 20 of a frame, rx_dv stays high -> all outputs 0 next cycle, rest of frame dropped, no frame_done. The next frame decodes correctly.
